// File: rtl/afifo_rd_burst_ctrl_if.sv
// Read-port and output-stream bundle of the async FIFO read sequencer.
// master: sequencer side (drives read enable and stream); slave: FIFO/sink side.
interface afifo_rd_burst_ctrl_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int LEVEL_WIDTH = 9
);
   logic                   fifo_rd_en;
   logic                   fifo_rd_empty;
   logic [DATA_WIDTH-1:0]  fifo_rd_data;
   logic [LEVEL_WIDTH-1:0] fifo_rd_water_level;
   logic                   m_valid;
   logic [DATA_WIDTH-1:0]  m_data;
   logic                   m_last;
   logic                   m_ready;

   modport master (
      output fifo_rd_en, m_valid, m_data, m_last,
      input  fifo_rd_empty, fifo_rd_data, fifo_rd_water_level, m_ready
   );

   modport slave (
      input  fifo_rd_en, m_valid, m_data, m_last,
      output fifo_rd_empty, fifo_rd_data, fifo_rd_water_level, m_ready
   );
endinterface

// File: rtl/afifo_rd_burst_ctrl.sv
// Read-side burst sequencer for the async FIFO; first beat RD_LATENCY+1 cycles after the first read.
// m_ready low stalls the stream; reads pause once 4 beats are outstanding, so the skid buffer never overflows.
module afifo_rd_burst_ctrl #(
   parameter int DATA_WIDTH  = 16,
   parameter int LEVEL_WIDTH = 9,
   parameter int RD_LATENCY  = 1,
   parameter int BURST_LEN   = 16,
   parameter int TIMEOUT     = 255
) (
   input  logic                 rd_clk,
   input  logic                 rd_rst_n,
   input  logic                 flush,
   output logic                 busy,
   afifo_rd_burst_ctrl_if.master bus
);
   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

   localparam logic [LEVEL_WIDTH-1:0] BLEN_FULL = LEVEL_WIDTH'(BURST_LEN);
   localparam logic [LEVEL_WIDTH-1:0] ONE       = LEVEL_WIDTH'(1);
   localparam logic [15:0]            TMO_LAST  = 16'(TIMEOUT - 1);

   state_t                 state, state_nxt;
   logic [LEVEL_WIDTH-1:0] blen, blen_nxt;
   logic [LEVEL_WIDTH-1:0] issued, sent;
   logic [15:0]            tmo_cnt;
   logic [2:0]             occ, fill;
   logic [1:0]             wr_ptr, rd_ptr;
   logic [DATA_WIDTH-1:0]  skid [4];
   logic [RD_LATENCY-1:0]  rd_pipe;
   logic                   rd_en, accept, start, push;

   assign rd_en  = (state == BURST) && !bus.fifo_rd_empty && (issued < blen) && (occ < 3'd4);
   assign push   = rd_pipe[RD_LATENCY-1];
   assign accept = bus.m_valid && bus.m_ready;

   assign bus.fifo_rd_en = rd_en;
   assign bus.m_valid    = (fill != 3'd0);
   assign bus.m_data     = bus.m_valid ? skid[rd_ptr] : '0;
   assign bus.m_last     = bus.m_valid && (sent == blen - ONE);
   assign busy           = (state != IDLE);

   always_comb begin
      state_nxt = state;
      blen_nxt  = blen;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.fifo_rd_water_level >= BLEN_FULL) begin
               state_nxt = BURST;
               blen_nxt  = BLEN_FULL;
               start     = 1'b1;
            end else if (!bus.fifo_rd_empty && (tmo_cnt == TMO_LAST || flush)) begin
               // The synchronised level can lag the empty flag; never start a zero-length burst.
               state_nxt = BURST;
               blen_nxt  = (bus.fifo_rd_water_level == '0) ? ONE : bus.fifo_rd_water_level;
               start     = 1'b1;
            end
         end
         BURST:   if (rd_en && issued == blen - ONE) state_nxt = DRAIN;
         DRAIN:   if (accept && bus.m_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         state   <= IDLE;
         blen    <= '0;
         issued  <= '0;
         sent    <= '0;
         tmo_cnt <= '0;
         occ     <= '0;
         fill    <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         rd_pipe <= '0;
      end else begin
         state <= state_nxt;
         blen  <= blen_nxt;

         if (start)      issued <= '0;
         else if (rd_en) issued <= issued + ONE;

         if (start)       sent <= '0;
         else if (accept) sent <= sent + ONE;

         if (state != IDLE || bus.fifo_rd_empty || start) tmo_cnt <= '0;
         else                                              tmo_cnt <= tmo_cnt + 16'd1;

         occ  <= occ + 3'(rd_en) - 3'(accept);
         fill <= fill + 3'(push) - 3'(accept);

         rd_pipe <= (rd_pipe << 1) | RD_LATENCY'(rd_en);
         if (push)   wr_ptr <= wr_ptr + 2'd1;
         if (accept) rd_ptr <= rd_ptr + 2'd1;
      end
   end

   always_ff @(posedge rd_clk) begin
      if (push) skid[wr_ptr] <= bus.fifo_rd_data;
   end
endmodule

// File: tb/tb_afifo_rd_burst_ctrl.sv
// Directed bench: two sequencers (read latency 1 and 2) share stimulus, each fed by its own FIFO model.
// Accepted beats are logged per lane and compared against hand-derived word sequences and cycle timings.
module tb_afifo_rd_burst_ctrl;
   localparam int DW = 16;
   localparam int LW = 9;

   logic rd_clk = 1'b0;
   logic rd_rst_n = 1'b0;
   logic flush = 1'b0;
   logic m_ready = 1'b1;
   logic busy_a, busy_b;
   int   wr_target = 0;

   int n_chk = 0;
   int n_err = 0;

   always #5 rd_clk = ~rd_clk;

   afifo_rd_burst_ctrl_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) bus_a ();
   afifo_rd_burst_ctrl_if #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW)) bus_b ();

   afifo_rd_burst_ctrl #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .RD_LATENCY(1), .BURST_LEN(16), .TIMEOUT(255))
      u_dut_a (.rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .flush(flush), .busy(busy_a), .bus(bus_a));
   afifo_rd_burst_ctrl #(.DATA_WIDTH(DW), .LEVEL_WIDTH(LW), .RD_LATENCY(2), .BURST_LEN(16), .TIMEOUT(255))
      u_dut_b (.rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .flush(flush), .busy(busy_b), .bus(bus_b));

   // FIFO models: word n carries 16'h1000+n; the level is exact and updates on the read clock.
   logic [DW-1:0] q_a[$], q_b[$];
   logic [DW-1:0] d_a = '0, d1_b = '0, d2_b = '0;
   logic [LW-1:0] lvl_a = '0, lvl_b = '0;
   int            wr_a = 0, wr_b = 0;

   assign bus_a.fifo_rd_empty       = (lvl_a == '0);
   assign bus_a.fifo_rd_water_level = lvl_a;
   assign bus_a.fifo_rd_data        = d_a;
   assign bus_a.m_ready             = m_ready;
   assign bus_b.fifo_rd_empty       = (lvl_b == '0);
   assign bus_b.fifo_rd_water_level = lvl_b;
   assign bus_b.fifo_rd_data        = d2_b;
   assign bus_b.m_ready             = m_ready;

   always @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         q_a.delete();
         wr_a  <= wr_target;
         lvl_a <= '0;
      end else begin
         if (bus_a.fifo_rd_en) d_a <= q_a.pop_front();
         if (wr_a < wr_target) begin
            q_a.push_back(16'(32'h1000 + wr_a));
            wr_a <= wr_a + 1;
         end
         lvl_a <= LW'(q_a.size());
      end
   end

   always @(posedge rd_clk) begin
      if (!rd_rst_n) begin
         q_b.delete();
         wr_b  <= wr_target;
         lvl_b <= '0;
      end else begin
         d2_b <= d1_b;
         if (bus_b.fifo_rd_en) d1_b <= q_b.pop_front();
         if (wr_b < wr_target) begin
            q_b.push_back(16'(32'h1000 + wr_b));
            wr_b <= wr_b + 1;
         end
         lvl_b <= LW'(q_b.size());
      end
   end

   // Stream monitors: log accepted beats, track outstanding reads and stall stability.
   logic [DW-1:0] obeat_a[$], obeat_b[$];
   logic          olast_a[$], olast_b[$];
   int            outst_a = 0, outst_b = 0, max_a = 0, max_b = 0, stab_a = 0, stab_b = 0;
   logic          held_a = 1'b0, held_b = 1'b0, hl_a = 1'b0, hl_b = 1'b0;
   logic [DW-1:0] hd_a = '0, hd_b = '0;

   always @(negedge rd_clk) begin
      if (!rd_rst_n) begin
         outst_a = 0;
         held_a  = 1'b0;
      end else begin
         if (held_a && (!bus_a.m_valid || bus_a.m_data !== hd_a || bus_a.m_last !== hl_a)) stab_a++;
         outst_a = outst_a + int'(bus_a.fifo_rd_en) - int'(bus_a.m_valid && m_ready);
         if (outst_a > max_a) max_a = outst_a;
         if (bus_a.m_valid && m_ready) begin
            obeat_a.push_back(bus_a.m_data);
            olast_a.push_back(bus_a.m_last);
         end
         held_a = bus_a.m_valid && !m_ready;
         hd_a   = bus_a.m_data;
         hl_a   = bus_a.m_last;
      end
   end

   always @(negedge rd_clk) begin
      if (!rd_rst_n) begin
         outst_b = 0;
         held_b  = 1'b0;
      end else begin
         if (held_b && (!bus_b.m_valid || bus_b.m_data !== hd_b || bus_b.m_last !== hl_b)) stab_b++;
         outst_b = outst_b + int'(bus_b.fifo_rd_en) - int'(bus_b.m_valid && m_ready);
         if (outst_b > max_b) max_b = outst_b;
         if (bus_b.m_valid && m_ready) begin
            obeat_b.push_back(bus_b.m_data);
            olast_b.push_back(bus_b.m_last);
         end
         held_b = bus_b.m_valid && !m_ready;
         hd_b   = bus_b.m_data;
         hl_b   = bus_b.m_last;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // n consecutive logged beats starting at 'from' must be words word0.. in order; optional m_last on the final one.
   task automatic chk_beats(input string tag, input bit lane_b, input int from, input int word0,
                            input int n, input bit last_end);
      logic [16:0] got, exp;
      for (int i = 0; i < n; i++) begin
         if (lane_b) got = (from + i < obeat_b.size()) ? {olast_b[from+i], obeat_b[from+i]} : 17'h1ffff;
         else        got = (from + i < obeat_a.size()) ? {olast_a[from+i], obeat_a[from+i]} : 17'h1ffff;
         exp = {last_end && (i == n - 1), 16'(32'h1000 + word0 + i)};
         chk(tag, 32'(got), 32'(exp));
      end
   endtask

   int  m_a, m_b, rst_at, act;
   int  t_en_a, t_v_a, t_en_b, t_v_b, t_l1_a, t_l1_b, t_f_a, t_r_a, rem_a;
   logic prev_busy_a;

   initial begin
      repeat (3) @(posedge rd_clk);
      @(negedge rd_clk);
      chk("rst_m_valid", 32'(bus_a.m_valid), 0);
      chk("rst_rd_en",   32'(bus_a.fifo_rd_en), 0);
      chk("rst_m_last",  32'(bus_a.m_last), 0);
      chk("rst_m_data",  32'(bus_a.m_data), 0);
      chk("rst_busy_a",  32'(busy_a), 0);
      chk("rst_busy_b",  32'(busy_b), 0);
      rd_rst_n = 1'b1;

      // Full burst of 16 from 20 words, then the 4 leftovers leave on timeout.
      m_a = obeat_a.size(); m_b = obeat_b.size();
      t_en_a = -1; t_v_a = -1; t_en_b = -1; t_v_b = -1; t_l1_a = -1; t_l1_b = -1;
      t_f_a = -1; t_r_a = -1; rem_a = -1; prev_busy_a = 1'b0;
      wr_target = 20;
      for (int c = 0; c < 340; c++) begin
         @(posedge rd_clk); #1;
         @(negedge rd_clk);
         if (bus_a.fifo_rd_en && t_en_a < 0) t_en_a = c;
         if (bus_a.m_valid && t_v_a < 0)     t_v_a = c;
         if (bus_b.fifo_rd_en && t_en_b < 0) t_en_b = c;
         if (bus_b.m_valid && t_v_b < 0)     t_v_b = c;
         if (bus_a.m_valid && m_ready && bus_a.m_last && t_l1_a < 0) t_l1_a = c;
         if (bus_b.m_valid && m_ready && bus_b.m_last && t_l1_b < 0) t_l1_b = c;
         if (prev_busy_a && !busy_a && t_f_a < 0) begin t_f_a = c; rem_a = int'(lvl_a); end
         if (!prev_busy_a && busy_a && t_f_a >= 0 && t_r_a < 0) t_r_a = c;
         prev_busy_a = busy_a;
      end
      chk("full_first_rd_en", 32'(t_en_a), 16);
      chk("full_lat1_valid",  32'(t_v_a - t_en_a), 2);
      chk("full_lat2_valid",  32'(t_v_b - t_en_b), 3);
      chk("full_gapless_a",   32'(t_l1_a - t_v_a), 15);
      chk("full_gapless_b",   32'(t_l1_b - t_v_b), 15);
      chk("full_busy_fall",   32'(t_f_a - t_l1_a), 1);
      chk("full_remaining",   32'(rem_a), 4);
      chk("tmo_idle_cycles",  32'(t_r_a - t_f_a), 255);
      chk("full_cnt_a",       32'(obeat_a.size() - m_a), 20);
      chk("full_cnt_b",       32'(obeat_b.size() - m_b), 20);
      chk_beats("full_beat_a", 1'b0, m_a, 0, 16, 1'b1);
      chk_beats("full_beat_b", 1'b1, m_b, 0, 16, 1'b1);
      chk_beats("tmo_beat_a",  1'b0, m_a + 16, 16, 4, 1'b1);
      chk_beats("tmo_beat_b",  1'b1, m_b + 16, 16, 4, 1'b1);
      chk("tmo_busy_end",     32'(busy_a || busy_b), 0);

      // Flush of 3 buffered words.
      m_a = obeat_a.size(); m_b = obeat_b.size(); t_en_a = -1;
      wr_target = 23;
      for (int c = 0; c < 40; c++) begin
         @(posedge rd_clk); #1;
         flush = (c == 10);
         @(negedge rd_clk);
         if (bus_a.fifo_rd_en && t_en_a < 0) t_en_a = c;
      end
      chk("flush_start", 32'(t_en_a), 11);
      chk("flush_cnt_a", 32'(obeat_a.size() - m_a), 3);
      chk_beats("flush_beat_a", 1'b0, m_a, 20, 3, 1'b1);
      chk_beats("flush_beat_b", 1'b1, m_b, 20, 3, 1'b1);

      // Flush with the FIFO empty must do nothing.
      act = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge rd_clk); #1;
         flush = (c == 2);
         @(negedge rd_clk);
         if (busy_a || busy_b || bus_a.fifo_rd_en || bus_b.fifo_rd_en) act++;
      end
      chk("flush_empty_idle", 32'(act), 0);

      // Back-pressure: ready 1-0-0-1 then low for 20 cycles mid-burst.
      m_a = obeat_a.size(); m_b = obeat_b.size();
      wr_target = 39;
      for (int c = 0; c < 100; c++) begin
         @(posedge rd_clk); #1;
         m_ready = !((c == 20) || (c == 21) || (c >= 23 && c <= 42));
         @(negedge rd_clk);
      end
      m_ready = 1'b1;
      chk("bp_cnt_a",  32'(obeat_a.size() - m_a), 16);
      chk("bp_cnt_b",  32'(obeat_b.size() - m_b), 16);
      chk_beats("bp_beat_a", 1'b0, m_a, 23, 16, 1'b1);
      chk_beats("bp_beat_b", 1'b1, m_b, 23, 16, 1'b1);
      chk("bp_max_outstanding_a", 32'(max_a), 4);
      chk("bp_max_outstanding_b", 32'(max_b), 4);
      chk("bp_stable_a", 32'(stab_a), 0);
      chk("bp_stable_b", 32'(stab_b), 0);

      // Reset while beat 7 is on the bus, then a fresh 16-word refill.
      m_a = obeat_a.size(); m_b = obeat_b.size();
      t_v_a = -1; rst_at = -1;
      wr_target = 59;
      for (int c = 0; c < 110; c++) begin
         @(posedge rd_clk); #1;
         rd_rst_n = !(rst_at >= 0 && c == rst_at);
         if (rst_at >= 0 && c == rst_at + 1) wr_target = 75;
         @(negedge rd_clk);
         if (bus_a.m_valid && t_v_a < 0) begin t_v_a = c; rst_at = c + 6; end
         if (rst_at >= 0 && c == rst_at + 1) begin
            chk("rst_mid_m_valid", 32'(bus_a.m_valid), 0);
            chk("rst_mid_rd_en",   32'(bus_a.fifo_rd_en), 0);
            chk("rst_mid_busy",    32'({busy_a, busy_b}), 0);
         end
      end
      rd_rst_n = 1'b1;
      chk("rst_cnt_a", 32'(obeat_a.size() - m_a), 22);
      chk("rst_cnt_b", 32'(obeat_b.size() - m_b), 21);
      chk_beats("rst_pre_a",  1'b0, m_a, 39, 6, 1'b0);
      chk_beats("rst_pre_b",  1'b1, m_b, 39, 5, 1'b0);
      chk_beats("rst_post_a", 1'b0, m_a + 6, 59, 16, 1'b1);
      chk_beats("rst_post_b", 1'b1, m_b + 5, 59, 16, 1'b1);
      chk("end_busy", 32'(busy_a || busy_b), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
